// File: rtl/motion_pkg.sv
// motion_pkg: shared definitions for the motion command sequencer.
//   - AXES, PULSE_W: motor channel count and pulse-count width.
//   - sched_state_t: scheduler states.
//   - motion_cmd_t: one queued move command {axis, pulses}.
//   - axis_onehot(): axis index to one-hot motor select.
package motion_pkg;

    localparam int AXES    = 6;
    localparam int PULSE_W = 10;

    typedef enum logic [1:0] {
        WAIT_HOME = 2'd0,
        IDLE      = 2'd1,
        ISSUE     = 2'd2,
        RUN       = 2'd3
    } sched_state_t;

    typedef struct packed {
        logic [2:0]         axis;
        logic [PULSE_W-1:0] pulses;
    } motion_cmd_t;

    localparam int CMD_W = $bits(motion_cmd_t);

    // Out-of-range axis indices give all zeros; callers filter them first.
    function automatic logic [AXES-1:0] axis_onehot(input logic [2:0] axis);
        logic [AXES-1:0] oh;
        for (int i = 0; i < AXES; i++) begin
            oh[i] = (axis == 3'(i));
        end
        return oh;
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// cmd_fifo: synchronous show-ahead FIFO with occupancy level.
//   clk, rst_n   : clock, synchronous active-low reset
//   push, wdata  : write request and data (ignored when full unless popping)
//   pop          : remove head entry (ignored when empty)
//   rdata        : current head entry
//   full, empty  : occupancy flags
//   level        : number of stored entries
// DEPTH must be a power of two so the pointers wrap naturally.
module cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 13,
    localparam int AW   = $clog2(DEPTH),
    localparam int LW   = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [LW-1:0]    level
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [LW-1:0]    count_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign full  = (count_r == LW'(DEPTH));
    assign empty = (count_r == {LW{1'b0}});
    assign level = count_r;
    assign rdata = mem_r[rd_ptr_r];

    // A full queue still takes a write when the head leaves in the same cycle.
    assign do_pop_s  = pop && !empty;
    assign do_push_s = push && (!full || do_pop_s);

    // Storage, pointers and occupancy count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {LW{1'b0}};
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= wdata;
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + LW'(1);
                2'b01:   count_r <= count_r - LW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/motion_scheduler.sv
// motion_scheduler: command sequencer in front of the six-axis Pulse generator.
// Commands are queued from the host, held until every axis has homed, and then
// issued one at a time over the one-hot Motor / PulseNum handshake.
//   sysclk, rst_n         : clock, synchronous active-low reset
//   cmd_valid/cmd_ready   : host command handshake; cmd_axis, cmd_pulses payload
//   err_clr               : clears the sticky error flags
//   initFlag              : per-axis homing-done flags
//   Busy                  : Pulse move in progress
//   Motor, PulseNum       : move request to Pulse
//   sched_busy            : queue non-empty or move in flight
//   done                  : one-cycle pulse per completed (or discarded) move
//   err_axis              : sticky, a command with an invalid axis was dropped
//   err_timeout           : sticky, Busy never acknowledged an issued move
//   queue_level           : queued entry count
// Optional feature macro SCHED_TIMEOUT_EN: bounds the wait for Busy to
// ACK_TIMEOUT cycles; without it the wait is unbounded and err_timeout is 0.
module motion_scheduler
    import motion_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int ACK_TIMEOUT = 64
) (
    input  logic                          sysclk,
    input  logic                          rst_n,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [2:0]                    cmd_axis,
    input  logic [PULSE_W-1:0]            cmd_pulses,
    input  logic                          err_clr,
    input  logic [AXES-1:0]               initFlag,
    input  logic                          Busy,
    output logic [AXES-1:0]               Motor,
    output logic [PULSE_W-1:0]            PulseNum,
    output logic                          sched_busy,
    output logic                          done,
    output logic                          err_axis,
    output logic                          err_timeout,
    output logic [$clog2(FIFO_DEPTH):0]   queue_level
);

    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    sched_state_t       state_r;
    sched_state_t       state_s;
    logic [AXES-1:0]    motor_r;
    logic [AXES-1:0]    motor_s;
    logic [PULSE_W-1:0] pulse_num_r;
    logic [PULSE_W-1:0] pulse_num_s;
    logic               done_r;
    logic               done_s;
    logic               err_axis_r;
    logic               err_axis_set_s;
    logic               pop_s;
    logic               homed_s;

    motion_cmd_t        wr_cmd_s;
    motion_cmd_t        head_s;
    logic [CMD_W-1:0]   head_bits_s;
    logic               fifo_full_s;
    logic               fifo_empty_s;
    logic [LVL_W-1:0]   level_s;

    assign wr_cmd_s.axis   = cmd_axis;
    assign wr_cmd_s.pulses = cmd_pulses;
    assign head_s          = motion_cmd_t'(head_bits_s);
    assign homed_s         = &initFlag;

    cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (CMD_W)
    ) u_cmd_fifo (
        .clk   (sysclk),
        .rst_n (rst_n),
        .push  (cmd_valid),
        .pop   (pop_s),
        .wdata (wr_cmd_s),
        .rdata (head_bits_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .level (level_s)
    );

`ifdef SCHED_TIMEOUT_EN
    localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);

    logic [TMO_W-1:0] tmo_cnt_r;
    logic             tmo_set_s;
    logic             err_timeout_r;
`endif

    // Next-state, move request and status decode.
    always_comb begin
        state_s        = state_r;
        motor_s        = motor_r;
        pulse_num_s    = pulse_num_r;
        done_s         = 1'b0;
        pop_s          = 1'b0;
        err_axis_set_s = 1'b0;
`ifdef SCHED_TIMEOUT_EN
        tmo_set_s      = 1'b0;
`endif
        case (state_r)
            WAIT_HOME: begin
                if (homed_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = WAIT_HOME;
                end
            end
            IDLE: begin
                // Losing homing takes priority over issuing; Busy high here is
                // external motion and blocks the pop.
                if (!homed_s) begin
                    state_s = WAIT_HOME;
                end else if (!fifo_empty_s && !Busy) begin
                    pop_s = 1'b1;
                    if (head_s.axis >= 3'(AXES)) begin
                        err_axis_set_s = 1'b1;
                    end else if (head_s.pulses == {PULSE_W{1'b0}}) begin
                        done_s = 1'b1;
                    end else begin
                        motor_s     = axis_onehot(head_s.axis);
                        pulse_num_s = head_s.pulses;
                        state_s     = ISSUE;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            ISSUE: begin
                if (Busy) begin
                    motor_s = {AXES{1'b0}};
                    state_s = RUN;
`ifdef SCHED_TIMEOUT_EN
                end else if (tmo_cnt_r == TMO_LAST) begin
                    tmo_set_s = 1'b1;
                    motor_s   = {AXES{1'b0}};
                    done_s    = 1'b1;
                    state_s   = IDLE;
`endif
                end else begin
                    state_s = ISSUE;
                end
            end
            RUN: begin
                if (!Busy) begin
                    done_s  = 1'b1;
                    state_s = IDLE;
                end else begin
                    state_s = RUN;
                end
            end
            default: begin
                motor_s = {AXES{1'b0}};
                state_s = WAIT_HOME;
            end
        endcase
    end

    // State and registered outputs; a new error wins over err_clr.
    always_ff @(posedge sysclk) begin
        if (!rst_n) begin
            state_r     <= WAIT_HOME;
            motor_r     <= {AXES{1'b0}};
            pulse_num_r <= {PULSE_W{1'b0}};
            done_r      <= 1'b0;
            err_axis_r  <= 1'b0;
        end else begin
            state_r     <= state_s;
            motor_r     <= motor_s;
            pulse_num_r <= pulse_num_s;
            done_r      <= done_s;
            err_axis_r  <= err_axis_set_s | (err_axis_r & ~err_clr);
        end
    end

`ifdef SCHED_TIMEOUT_EN
    // Acknowledge timer: counts cycles spent in ISSUE, cleared on any exit.
    always_ff @(posedge sysclk) begin
        if (!rst_n) begin
            tmo_cnt_r     <= {TMO_W{1'b0}};
            err_timeout_r <= 1'b0;
        end else begin
            if (state_r == ISSUE && state_s == ISSUE) begin
                tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
            end else begin
                tmo_cnt_r <= {TMO_W{1'b0}};
            end
            err_timeout_r <= tmo_set_s | (err_timeout_r & ~err_clr);
        end
    end

    assign err_timeout = err_timeout_r;
`else
    assign err_timeout = 1'b0;
`endif

    assign Motor       = motor_r;
    assign PulseNum    = pulse_num_r;
    assign done        = done_r;
    assign err_axis    = err_axis_r;
    assign queue_level = level_s;
    assign cmd_ready   = ~fifo_full_s;
    assign sched_busy  = (state_r == ISSUE) || (state_r == RUN) ||
                         (level_s != {LVL_W{1'b0}});

endmodule
